bb_snoop_queue: RTL and testbench

Buffers the write-snoop stream produced by the Blackbone bus (`snoop_adr`/`snoop_en`) and delivers it as a valid/ready invalidation stream to a downstream cache or tag controller. Snoops occur every cycle a write is on the bus, and the consumer may stall, so the block provides:

- a small FIFO of invalidation addresses;
- coalescing of duplicate line addresses;
- bus back-pressure through the bus hold handshake;
- a sticky overflow flag.

---
 rtl/bb_snoop_queue.sv | 115 +++++++++++
 tb/tb_bb_snoop_queue.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bb_snoop_queue.sv
// ============================================================================
// Module   : bb_snoop_queue
// Purpose  : Line-coalescing FIFO turning bus write snoops into a valid/ready
//            invalidation stream, with bus hold and sticky overflow.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bb_snoop_queue #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH          = 4,
  parameter int LINE_OFFSET    = 2,
  parameter int HOLD_THRESHOLD = DEPTH - 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDR_WIDTH-1:0]    snoop_adr_i,
  input  logic                     snoop_en_i,
  output logic [ADDR_WIDTH-1:0]    inv_adr_o,
  output logic                     inv_valid_o,
  input  logic                     inv_ready_i,
  output logic                     bus_hold_o,
  input  logic                     bus_hold_ack_i,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_lvl_w = c_ptr_w + 1;

  localparam logic [ADDR_WIDTH-1:0] c_all_ones  = '1;
  localparam logic [ADDR_WIDTH-1:0] c_line_mask = c_all_ones << LINE_OFFSET;
  localparam logic [c_lvl_w-1:0]    c_depth     = c_lvl_w'(DEPTH);
  localparam logic [c_lvl_w-1:0]    c_hold_thr  = c_lvl_w'(HOLD_THRESHOLD);

  logic [ADDR_WIDTH-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_lvl_w-1:0]    r_level;
  logic                  r_bus_hold;
  logic                  r_overflow;

  logic [ADDR_WIDTH-1:0] w_line;
  logic                  w_valid;
  logic                  w_pop;
  logic [DEPTH-1:0]      w_occupied;
  logic [DEPTH-1:0]      w_hit;
  logic                  w_coalesce;
  logic                  w_full;
  logic                  w_push;
  logic                  w_drop;
  logic [c_lvl_w-1:0]    w_level_next;

  // The arbiter acknowledge carries no control meaning here; snoops seen
  // while it is asserted are processed like any other.
  logic w_unused_ack;
  assign w_unused_ack = bus_hold_ack_i;

  assign w_line  = snoop_adr_i & c_line_mask;
  assign w_valid = (r_level != '0);
  assign w_pop   = w_valid & inv_ready_i;
  assign w_full  = (r_level == c_depth);

  // A hit on the head that leaves this cycle must not absorb the snoop,
  // otherwise the write would never be followed by an invalidation.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [c_ptr_w-1:0] w_dist;
    assign w_dist         = c_ptr_w'(gi) - r_rd_ptr;
    assign w_occupied[gi] = ({1'b0, w_dist} < r_level);
    assign w_hit[gi]      = w_occupied[gi]
                          && (r_mem[gi] == w_line)
                          && !(w_pop && (c_ptr_w'(gi) == r_rd_ptr));
  end

  assign w_coalesce   = snoop_en_i & (|w_hit);
  assign w_push       = snoop_en_i & ~w_coalesce & (~w_full | w_pop);
  assign w_drop       = snoop_en_i & ~w_coalesce & w_full & ~w_pop;
  assign w_level_next = r_level + c_lvl_w'(w_push) - c_lvl_w'(w_pop);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_level    <= '0;
      r_bus_hold <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_level    <= w_level_next;
      r_bus_hold <= (w_level_next >= c_hold_thr);
      r_overflow <= r_overflow | w_drop;
    end
  end

  // Storage needs no reset: the head output is gated by occupancy.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_line;
    end
  end

  assign inv_valid_o = w_valid;
  assign inv_adr_o   = w_valid ? r_mem[r_rd_ptr] : '0;
  assign bus_hold_o  = r_bus_hold;
  assign overflow_o  = r_overflow;
  assign level_o     = r_level;

endmodule

`default_nettype wire

// File: tb/tb_bb_snoop_queue.sv
// ============================================================================
// Module   : tb_bb_snoop_queue
// Purpose  : Directed scoreboard bench for bb_snoop_queue (DEPTH 4, hold 3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bb_snoop_queue;

  localparam int M_PUSH = 0;
  localparam int M_COAL = 1;
  localparam int M_DROP = 2;
  localparam logic [31:0] c_mask = 32'hFFFF_FFFC;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] snoop_adr_i;
  logic        snoop_en_i;
  logic [31:0] inv_adr_o;
  logic        inv_valid_o;
  logic        inv_ready_i;
  logic        bus_hold_o;
  logic        bus_hold_ack_i;
  logic        overflow_o;
  logic [2:0]  level_o;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sb[$];
  logic        exp_ovf  = 1'b0;

  always #5 clk_i = ~clk_i;

  bb_snoop_queue #(
    .ADDR_WIDTH(32), .DEPTH(4), .LINE_OFFSET(2), .HOLD_THRESHOLD(3)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .snoop_adr_i(snoop_adr_i), .snoop_en_i(snoop_en_i),
    .inv_adr_o(inv_adr_o), .inv_valid_o(inv_valid_o), .inv_ready_i(inv_ready_i),
    .bus_hold_o(bus_hold_o), .bus_hold_ack_i(bus_hold_ack_i),
    .overflow_o(overflow_o), .level_o(level_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs just after the falling edge, score the pop
  // against the queue, then check registered outputs after the rising edge.
  task automatic step(input logic en, input logic [31:0] adr, input logic rdy, input int mode);
    logic [31:0] exp_head;
    snoop_en_i  = en;
    snoop_adr_i = adr;
    inv_ready_i = rdy;
    if (rdy && sb.size() > 0) begin
      exp_head = sb.pop_front();
      chk("pop_adr", inv_adr_o, exp_head);
    end
    if (en) begin
      if (mode == M_PUSH) sb.push_back(adr & c_mask);
      else if (mode == M_DROP) exp_ovf = 1'b1;
    end
    @(posedge clk_i);
    #1;
    snoop_en_i  = 1'b0;
    inv_ready_i = 1'b0;
    chk("level", 32'(level_o), 32'(sb.size()));
    chk("valid", 32'(inv_valid_o), 32'(sb.size() != 0));
    chk("hold", 32'(bus_hold_o), 32'(sb.size() >= 3));
    chk("overflow", 32'(overflow_o), 32'(exp_ovf));
    if (sb.size() > 0) chk("head", inv_adr_o, sb[0]);
    @(negedge clk_i);
  endtask

  task automatic drain_all();
    for (int i = 0; i < 6 && sb.size() > 0; i++) step(1'b0, 32'h0, 1'b1, M_PUSH);
  endtask

  initial begin
    rst_i          = 1'b0;
    snoop_adr_i    = '0;
    snoop_en_i     = 1'b0;
    inv_ready_i    = 1'b0;
    bus_hold_ack_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_valid", 32'(inv_valid_o), 32'd0);
    chk("rst_adr", inv_adr_o, 32'd0);
    chk("rst_hold", 32'(bus_hold_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Single snoop with offset bits stripped
    step(1'b1, 32'h1000_0007, 1'b0, M_PUSH);
    chk("single_adr", inv_adr_o, 32'h1000_0004);
    step(1'b0, 32'h0, 1'b1, M_PUSH);

    // Coalescing of same-line snoops
    step(1'b1, 32'h20, 1'b0, M_PUSH);
    step(1'b1, 32'h22, 1'b0, M_COAL);
    step(1'b1, 32'h20, 1'b0, M_COAL);
    step(1'b1, 32'h24, 1'b0, M_PUSH);
    drain_all();

    // Push and pop together while full
    for (int i = 0; i < 4; i++) step(1'b1, 32'h200 + 32'(4 * i), 1'b0, M_PUSH);
    step(1'b1, 32'h40, 1'b1, M_PUSH);
    drain_all();

    // Snoop matching only the departing head is re-queued
    step(1'b1, 32'h300, 1'b0, M_PUSH);
    step(1'b1, 32'h300, 1'b1, M_PUSH);
    drain_all();

    // Hold request and snoop accepted during acknowledge
    step(1'b1, 32'h400, 1'b0, M_PUSH);
    step(1'b1, 32'h404, 1'b0, M_PUSH);
    step(1'b1, 32'h408, 1'b0, M_PUSH);
    step(1'b0, 32'h0, 1'b1, M_PUSH);
    bus_hold_ack_i = 1'b1;
    step(1'b1, 32'h40C, 1'b0, M_PUSH);
    bus_hold_ack_i = 1'b0;
    drain_all();

    // Fill, overflow, drain, refill to exercise pointer wrap
    for (int i = 0; i < 4; i++) step(1'b1, 32'(4 * i), 1'b0, M_PUSH);
    step(1'b1, 32'h10, 1'b0, M_DROP);
    drain_all();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(4 * i), 1'b0, M_PUSH);
    drain_all();

    // Asynchronous reset between edges with entries queued
    for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + 32'(4 * i), 1'b0, M_PUSH);
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_level", 32'(level_o), 32'd0);
    chk("arst_valid", 32'(inv_valid_o), 32'd0);
    chk("arst_adr", inv_adr_o, 32'd0);
    chk("arst_hold", 32'(bus_hold_o), 32'd0);
    chk("arst_ovf", 32'(overflow_o), 32'd0);
    sb.delete();
    exp_ovf = 1'b0;
    @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    step(1'b1, 32'h80, 1'b0, M_PUSH);
    chk("post_rst_adr", inv_adr_o, 32'h80);
    drain_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
